// File: rtl/bin_cnt_sample_feeder.sv
// Streams the bin counts of each stored sample to the classifier and captures
// one winner ID per sample, for a host-requested number of samples.
module bin_cnt_sample_feeder #(
   parameter int unsigned BIN_NUM   = 1024,
   parameter int unsigned SAMPLE_AW = 8
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  logic [SAMPLE_AW:0]                   num_samples,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 mem_rd_en,
   output logic [SAMPLE_AW+$clog2(BIN_NUM)-1:0] mem_addr,
   input  logic [19:0]                          mem_rdata,
   input  logic                                 request_new_sample,
   output logic                                 trans_start,
   output logic [19:0]                          bin_cnt,
   output logic                                 bin_valid,
   input  logic                                 infer_ready,
   input  logic [4:0]                           winner_ID,
   output logic                                 result_valid,
   output logic [4:0]                           result_ID,
   output logic [SAMPLE_AW-1:0]                 result_sample
);

   localparam int unsigned BIN_AW = $clog2(BIN_NUM);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_REQ,
      FETCH,
      STREAM,
      WAIT_RESULT
   } state_t;

   state_t                state, state_nxt;
   logic [SAMPLE_AW:0]    num_lat;
   logic [SAMPLE_AW-1:0]  sample_idx;
   logic [BIN_AW-1:0]     bin_idx;
   logic [SAMPLE_AW:0]    idx_plus_one;
   logic                  rd_d1, first_d1, last_d1, last_pres;
   logic                  accept_start, zero_start, capture, last_sample;

   assign mem_addr     = {sample_idx, bin_idx};
   assign idx_plus_one = {1'b0, sample_idx} + {{SAMPLE_AW{1'b0}}, 1'b1};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode and per-cycle control strobes
   always_comb begin
      state_nxt    = state;
      accept_start = 1'b0;
      zero_start   = 1'b0;
      capture      = 1'b0;
      last_sample  = 1'b0;
      mem_rd_en    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept_start = 1'b1;
               if (num_samples == '0) zero_start = 1'b1;
               else                   state_nxt  = WAIT_REQ;
            end
         end
         WAIT_REQ: begin
            if (request_new_sample) state_nxt = FETCH;
         end
         FETCH: begin
            mem_rd_en = 1'b1;
            state_nxt = STREAM;
         end
         STREAM: begin
            // bin_idx wraps back to 0 after the last read; the state then
            // lingers until the final bin has left the read pipeline.
            mem_rd_en = (bin_idx != '0);
            if (last_pres) state_nxt = WAIT_RESULT;
         end
         WAIT_RESULT: begin
            if (infer_ready) begin
               capture = 1'b1;
               if (idx_plus_one == num_lat) begin
                  last_sample = 1'b1;
                  state_nxt   = IDLE;
               end else begin
                  state_nxt = WAIT_REQ;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: run bookkeeping, read pipeline and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy          <= 1'b0;
         done          <= 1'b0;
         num_lat       <= '0;
         sample_idx    <= '0;
         bin_idx       <= '0;
         rd_d1         <= 1'b0;
         first_d1      <= 1'b0;
         last_d1       <= 1'b0;
         last_pres     <= 1'b0;
         bin_valid     <= 1'b0;
         trans_start   <= 1'b0;
         bin_cnt       <= '0;
         result_valid  <= 1'b0;
         result_ID     <= '0;
         result_sample <= '0;
      end else begin
         done         <= zero_start | last_sample;
         result_valid <= capture;
         if (accept_start) begin
            num_lat    <= num_samples;
            sample_idx <= '0;
            bin_idx    <= '0;
            busy       <= (num_samples != '0);
         end
         if (last_sample) busy <= 1'b0;
         if (capture) begin
            result_ID     <= winner_ID;
            result_sample <= sample_idx;
            sample_idx    <= sample_idx + {{(SAMPLE_AW-1){1'b0}}, 1'b1};
         end
         if (mem_rd_en) bin_idx <= bin_idx + {{(BIN_AW-1){1'b0}}, 1'b1};
         rd_d1       <= mem_rd_en;
         first_d1    <= (state == FETCH);
         last_d1     <= mem_rd_en && (bin_idx == BIN_AW'(BIN_NUM - 1));
         bin_valid   <= rd_d1;
         trans_start <= first_d1;
         last_pres   <= last_d1;
         if (rd_d1) bin_cnt <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_bin_cnt_sample_feeder.sv
// Scoreboard bench for bin_cnt_sample_feeder: stimulus pushes expected reads,
// bins and results into queues; a negedge monitor pops and compares.
module tb_bin_cnt_sample_feeder;

   localparam int BN  = 1024;
   localparam int SAW = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [SAW:0]      num_samples = '0;
   logic              busy, done, mem_rd_en;
   logic [SAW+9:0]    mem_addr;
   logic [19:0]       mem_rdata = '0;
   logic              request_new_sample = 1'b0;
   logic              trans_start, bin_valid;
   logic [19:0]       bin_cnt;
   logic              infer_ready = 1'b0;
   logic [4:0]        winner_ID = '0;
   logic              result_valid;
   logic [4:0]        result_ID;
   logic [SAW-1:0]    result_sample;

   int unsigned       exp_addr[$];
   logic [20:0]       exp_bin[$];
   logic [12:0]       exp_res[$];
   int                errors = 0;
   int                checks = 0;
   int                done_cnt = 0;
   logic [19:0]       last_bin = '0;

   bin_cnt_sample_feeder #(.BIN_NUM(BN), .SAMPLE_AW(SAW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
      .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .request_new_sample(request_new_sample),
      .trans_start(trans_start), .bin_cnt(bin_cnt), .bin_valid(bin_valid),
      .infer_ready(infer_ready), .winner_ID(winner_ID),
      .result_valid(result_valid), .result_ID(result_ID),
      .result_sample(result_sample)
   );

   always #5 clk = ~clk;

   // Memory model: word at address a holds a, one-cycle read latency
   always @(posedge clk) if (mem_rd_en) mem_rdata <= 20'(mem_addr);

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops expected items whenever the DUT presents an output
   always @(negedge clk) begin
      if (rst_n) begin
         if (exp_addr.size() == 0) chk("unexpected_read", mem_rd_en, 0);
         else if (mem_rd_en)       chk("mem_addr", mem_addr, exp_addr.pop_front());
         if (bin_valid) begin
            if (exp_bin.size() == 0) chk("unexpected_bin", bin_valid, 0);
            else begin
               logic [20:0] e;
               e = exp_bin.pop_front();
               chk("bin_cnt", bin_cnt, e[19:0]);
               chk("trans_start", trans_start, e[20]);
            end
            last_bin = bin_cnt;
         end else begin
            chk("trans_start_idle", trans_start, 0);
            chk("bin_cnt_hold", bin_cnt, last_bin);
         end
         if (exp_res.size() == 0) chk("unexpected_result", result_valid, 0);
         else if (result_valid) begin
            logic [12:0] r;
            r = exp_res.pop_front();
            chk("result_ID", result_ID, r[12:8]);
            chk("result_sample", result_sample, r[7:0]);
         end
         if (done) done_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_rd_en"}, mem_rd_en, 0);
      chk({tag, "_addr"}, mem_addr, 0);
      chk({tag, "_trans"}, trans_start, 0);
      chk({tag, "_bin_cnt"}, bin_cnt, 0);
      chk({tag, "_bin_valid"}, bin_valid, 0);
      chk({tag, "_res_valid"}, result_valid, 0);
      chk({tag, "_res_id"}, result_ID, 0);
      chk({tag, "_res_sample"}, result_sample, 0);
   endtask

   task automatic begin_run(input int n);
      for (int s = 0; s < n; s++)
         for (int b = 0; b < BN; b++) begin
            exp_addr.push_back(s * BN + b);
            exp_bin.push_back({(b == 0), 20'(s * BN + b)});
         end
      start = 1'b1;
      num_samples = (SAW+1)'(n);
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_read();
      bit seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (mem_rd_en) begin seen = 1; break; end
      end
      chk("read_start", seen, 1);
   endtask

   task automatic wait_bins(input int n);
      int cnt = 0;
      for (int i = 0; i < 4000 && cnt < n; i++) begin
         @(negedge clk);
         if (bin_valid) cnt++;
      end
      chk("bins_seen", cnt, n);
   endtask

   task automatic wait_stream_end();
      bit seen = 0;
      bit ended = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (bin_valid) seen = 1;
         else if (seen) begin ended = 1; break; end
      end
      chk("stream_end", ended, 1);
   endtask

   task automatic give_result(input int id, input int s);
      tick(1);
      infer_ready = 1'b1;
      winner_ID = 5'(id);
      exp_res.push_back({5'(id), 8'(s)});
      tick(1);
      infer_ready = 1'b0;
   endtask

   initial begin
      int d0;
      // Reset state
      tick(3);
      check_all_zero("reset");
      rst_n = 1'b1;
      tick(2);

      // Single sample, request held high
      d0 = done_cnt;
      request_new_sample = 1'b1;
      begin_run(1);
      chk("busy_run", busy, 1);
      wait_stream_end();
      give_result(17, 0);
      tick(2);
      chk("single_done", done_cnt - d0, 1);
      chk("single_busy_clear", busy, 0);

      // Three samples, delayed requests, ignored mid-stream inputs and start
      d0 = done_cnt;
      request_new_sample = 1'b0;
      begin_run(3);
      for (int s = 0; s < 3; s++) begin
         tick(5);
         request_new_sample = 1'b1;
         wait_read();
         tick(1);
         request_new_sample = 1'b0;
         if (s == 1) begin
            wait_bins(300);
            tick(1);
            infer_ready = 1'b1;
            request_new_sample = 1'b1;
            winner_ID = 5'd9;
            tick(2);
            infer_ready = 1'b0;
            request_new_sample = 1'b0;
         end
         wait_stream_end();
         if (s == 0) begin
            tick(1);
            start = 1'b1;
            num_samples = 9'd1;
            tick(1);
            start = 1'b0;
            num_samples = '0;
            chk("busy_start_ignored", busy, 1);
         end
         give_result(s + 3, s);
         if (s < 2) chk("multi_no_early_done", done_cnt - d0, 0);
      end
      tick(2);
      chk("multi_done", done_cnt - d0, 1);
      chk("multi_busy_clear", busy, 0);

      // Zero samples
      tick(1);
      start = 1'b1;
      num_samples = '0;
      tick(1);
      start = 1'b0;
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      tick(1);
      chk("zero_done_pulse", done, 0);
      tick(3);

      // Reset at bin 500, then no resume and a clean restart
      request_new_sample = 1'b1;
      begin_run(2);
      wait_bins(500);
      tick(1);
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      exp_addr.delete();
      exp_bin.delete();
      exp_res.delete();
      last_bin = '0;
      tick(2);
      rst_n = 1'b1;
      tick(6);
      chk("no_resume_busy", busy, 0);
      d0 = done_cnt;
      begin_run(1);
      wait_stream_end();
      give_result(5, 0);
      tick(2);
      chk("restart_done", done_cnt - d0, 1);

      chk("addr_q_empty", exp_addr.size(), 0);
      chk("bin_q_empty", exp_bin.size(), 0);
      chk("res_q_empty", exp_res.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
